spi_ram: RTL
============

# spi_ram

Single-port byte memory that sits directly downstream of the SPI slave and consumes its 10-bit `rx_data`/`rx_valid` word stream. The top two bits of each received word are a command (write address, write data, read address, read data). The low byte is the address or payload. Read-data commands return a byte on `dout`/`tx_valid`, which feeds back into the SPI slave's `tx_data`/`tx_valid` for shifting out on MISO.

## Interface
- `MEM_DEPTH`, 256, number of byte locations.
- `ADDR_SIZE`, 8, address width in bits; 1..8; `MEM_DEPTH` = 2^`ADDR_SIZE`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `din` input 10: command word from the SPI slave; `din[9:8]` is the command, `din[7:0]` is the address or data.
- `rx_valid` input 1: `din` is valid this cycle; sampled on the rising edge of `clk`.
- `dout` output 8: read data to the SPI slave's `tx_data`.
- `tx_valid` output 1: one-cycle strobe; `dout` is valid.
- `cmd_err` output 1: one-cycle strobe; a read-data command was rejected.

## Operation
- Internal registers: `wr_addr` and `rd_addr` (each `ADDR_SIZE` bits), `rd_addr_ok` flag, and the `mem` array. `mem` is not reset.
- Nothing changes on a cycle with `rx_valid`=0, except that the `tx_valid` and `cmd_err` strobes clear.
- Address decode uses `din[ADDR_SIZE-1:0]`; the upper address bits are ignored.
- Command decode when `rx_valid`=1:
  - 2'b00 WR_ADDR: `wr_addr` ← `din[ADDR_SIZE-1:0]`.
  - 2'b01 WR_DATA: `mem[wr_addr]` ← `din[7:0]`.
  - 2'b10 RD_ADDR: `rd_addr` ← `din[ADDR_SIZE-1:0]`; `rd_addr_ok` ← 1.
  - 2'b11 RD_DATA with `rd_addr_ok`=1: `dout` ← `mem[rd_addr]`; `tx_valid` ← 1. `din[7:0]` is a don't-care.
  - 2'b11 RD_DATA with `rd_addr_ok`=0: `dout` holds its value; `tx_valid` stays 0; `cmd_err` ← 1.
- `dout` holds its last value until the next accepted RD_DATA.
- Back-to-back RD_DATA commands each produce a fresh one-cycle `tx_valid` pulse, so `tx_valid` can stay high on consecutive cycles.
- Read after write to the same address on a later cycle returns the newly written byte; there is no hazard because only one command arrives per cycle.
- Repeated WR_ADDR or RD_ADDR commands overwrite the address register; the last one wins.

## Timing
- Latency: RD_DATA sampled at edge N gives `dout` valid and `tx_valid`=1 after edge N, for exactly one cycle.
- `cmd_err` follows the same timing as `tx_valid`: asserted after edge N for one cycle.
- A write takes effect at the sampling edge; a RD_DATA on the very next cycle to the same address sees the new data.
- Reset values (asynchronous, on `rst_n`=0): `dout`=8'h00, `tx_valid`=0, `cmd_err`=0, `wr_addr`=0, `rd_addr`=0, `rd_addr_ok`=0.
- Reset mid-transaction: pending strobes drop immediately; `mem` contents are retained.
- After reset, a RD_DATA issued before any RD_ADDR raises `cmd_err`.

## Configuration
- Macro: `SPI_RAM_AUTOINC_EN`.
- Defined:
  - Each WR_DATA post-increments `wr_addr`, and each accepted RD_DATA post-increments `rd_addr`.
  - Both increments wrap from `MEM_DEPTH-1` to 0.
  - This allows burst transfers after a single address command.
- Undefined: both address registers change only on WR_ADDR / RD_ADDR.

## Test plan
- Reset, then WR_ADDR 0x12, WR_DATA 0xA5, RD_ADDR 0x12, RD_DATA → `dout`=0xA5, `tx_valid` high exactly one cycle, `cmd_err`=0.
- After reset, RD_DATA with no prior RD_ADDR → `cmd_err` one-cycle pulse, `tx_valid`=0, `dout`=0x00.
- Write 0x11 to address 0x00 and 0x22 to address 0xFF; RD_ADDR 0xFF, RD_DATA, RD_ADDR 0x00, RD_DATA → `dout` reads 0x22 then 0x11.
- Back-to-back RD_DATA on consecutive cycles → two consecutive `tx_valid` cycles.
  - Without `SPI_RAM_AUTOINC_EN`: same byte both times.
  - With `SPI_RAM_AUTOINC_EN`: bytes from addresses A and A+1.
- With `SPI_RAM_AUTOINC_EN`: WR_ADDR 0xFF, WR_DATA 0x33, WR_DATA 0x44 → `mem[0xFF]`=0x33, `mem[0x00]`=0x44.
- Write 0x5A to address 0x40, pulse `rst_n` low, then RD_ADDR 0x40, RD_DATA → `dout`=0x5A. During the reset pulse, `dout`=0x00 and `tx_valid`=0.

Source files
------------

// File: rtl/spi_ram.sv
// Byte RAM driven by the SPI slave's 10-bit command stream; returns read data on dout/tx_valid.
// Optional SPI_RAM_AUTOINC_EN: post-increment wr_addr on WR_DATA and rd_addr on accepted RD_DATA.
module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       cmd_err
);

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

`ifdef SPI_RAM_AUTOINC_EN
    localparam logic [ADDR_SIZE-1:0] ADDR_ONE = 1;
`endif

    logic [7:0]           mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 rd_addr_ok;
    logic [1:0]           cmd;
    logic                 mem_we;

    assign cmd    = din[9:8];
    assign mem_we = rx_valid && (cmd == WR_DATA);

    // Storage is deliberately outside the reset domain so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= din[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= 8'h00;
            tx_valid   <= 1'b0;
            cmd_err    <= 1'b0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            rd_addr_ok <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            cmd_err  <= 1'b0;
            if (rx_valid) begin
                unique case (cmd)
                    WR_ADDR: wr_addr <= din[ADDR_SIZE-1:0];
                    WR_DATA: begin
`ifdef SPI_RAM_AUTOINC_EN
                        wr_addr <= wr_addr + ADDR_ONE;
`endif
                    end
                    RD_ADDR: begin
                        rd_addr    <= din[ADDR_SIZE-1:0];
                        rd_addr_ok <= 1'b1;
                    end
                    RD_DATA: begin
                        if (rd_addr_ok) begin
                            dout     <= mem[rd_addr];
                            tx_valid <= 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
                            rd_addr  <= rd_addr + ADDR_ONE;
`endif
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
